io_bank: RTL and testbench

- N-channel bidirectional pad bank. Parametrised successor of the single simulation IO cell.
- Adds the following per channel:
  - 2+ stage input synchroniser
  - programmable glitch filter
  - edge/level event detection with sticky, clearable interrupt status
- Sits between the SoC pad ring and the GPIO/peripheral mux; one instance per pad group.

---
 rtl/io_bank.sv | 147 ++++++++++++++
 tb/tb_io_bank.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_bank.sv
// rtl/io_bank.sv - N-channel bidirectional pad bank with synchroniser, glitch filter and sticky interrupts
//
// Purpose:
//   One instance per pad group, placed between the pad ring and the GPIO/peripheral mux.
//   Each channel drives its pad from the core or tristates it. Pad input runs through a
//   synchroniser, an optional glitch filter and an edge/level event detector that feeds a
//   sticky, clearable interrupt status.
//
// Ports:
//   clk_in      in   1              bank clock
//   reset_int   in   1              asynchronous active-low reset
//   io_cfg      in   N_CH*CONF_WIDTH channel i config at [i*CONF_WIDTH +: CONF_WIDTH]
//                                   [0] dir (1 = input), [1] filt_en, [2] irq_en,
//                                   [4:3] mode (00 rise, 01 fall, 10 both, 11 level-high),
//                                   [5] open-drain select, higher bits ignored
//   from_core   in   N_CH           output data from core
//   to_core     out  N_CH           filtered input data to core
//   irq_clear   in   N_CH           per-channel status clear (level)
//   irq_status  out  N_CH           sticky event flags
//   irq         out  1              OR of irq_status
//   pad         io   N_CH           off-chip pads
//
// Build option:
//   IO_BANK_OPEN_DRAIN_EN - when defined, cfg[5] = 1 with dir = 0 makes the channel an
//   open-drain output whose pad level is read back through the filter/event path.

module io_bank #(
    parameter int N_CH        = 8,
    parameter int CONF_WIDTH  = 6,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 8
) (
    input  logic                       clk_in,
    input  logic                       reset_int,
    input  logic [N_CH*CONF_WIDTH-1:0] io_cfg,
    input  logic [N_CH-1:0]            from_core,
    output logic [N_CH-1:0]            to_core,
    input  logic [N_CH-1:0]            irq_clear,
    output logic [N_CH-1:0]            irq_status,
    output logic                       irq,
    inout  wire  [N_CH-1:0]            pad
);

    localparam int              CNT_W    = $clog2(FILT_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN - 1);

    typedef enum logic [1:0] {
        MODE_RISE  = 2'b00,
        MODE_FALL  = 2'b01,
        MODE_BOTH  = 2'b10,
        MODE_LEVEL = 2'b11
    } mode_e;

    genvar i;
    generate
        for (i = 0; i < N_CH; i++) begin : g_ch
            logic [CONF_WIDTH-1:0]  cfg;
            logic                   dir;
            logic                   filt_en;
            logic                   irq_en;
            logic                   od;
            logic                   rx_en;
            mode_e                  mode;
            logic [SYNC_STAGES-1:0] sync_q;
            logic                   sync;
            logic                   stable_q;
            logic                   stable_d;
            logic [CNT_W-1:0]       cnt_q;
            logic [CNT_W-1:0]       cnt_d;
            logic                   evt;
            logic                   status_q;
            logic                   unused_cfg;

            assign cfg        = io_cfg[i*CONF_WIDTH +: CONF_WIDTH];
            assign dir        = cfg[0];
            assign filt_en    = cfg[1];
            assign irq_en     = cfg[2];
            assign mode       = mode_e'(cfg[4:3]);
            assign unused_cfg = ^cfg[CONF_WIDTH-1:5];

`ifdef IO_BANK_OPEN_DRAIN_EN
            // Open-drain: only ever pull low; the external pull-up supplies the high level.
            assign od     = cfg[5] & ~dir;
            assign pad[i] = dir ? 1'bz : (od ? (from_core[i] ? 1'bz : 1'b0) : from_core[i]);
`else
            assign od     = 1'b0;
            assign pad[i] = dir ? 1'bz : from_core[i];
`endif

            // Receive path is live for inputs and for open-drain readback.
            assign rx_en = dir | od;
            assign sync  = sync_q[SYNC_STAGES-1];

            always_comb begin
                stable_d = stable_q;
                cnt_d    = '0;
                if (!rx_en) begin
                    stable_d = 1'b0;
                end else if (!filt_en) begin
                    stable_d = sync;
                end else if (sync != stable_q) begin
                    // Accept the new level only after FILT_LEN consecutive mismatching cycles.
                    if (cnt_q == CNT_LAST) begin
                        stable_d = sync;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            // Edges compare old vs next stable; level-high looks at the current stable value.
            always_comb begin
                evt = 1'b0;
                if (rx_en) begin
                    case (mode)
                        MODE_RISE:  evt = ~stable_q & stable_d;
                        MODE_FALL:  evt = stable_q & ~stable_d;
                        MODE_BOTH:  evt = stable_q ^ stable_d;
                        MODE_LEVEL: evt = stable_q;
                        default:    evt = 1'b0;
                    endcase
                end
            end

            always_ff @(posedge clk_in or negedge reset_int) begin
                if (!reset_int) begin
                    sync_q   <= '0;
                    stable_q <= 1'b0;
                    cnt_q    <= '0;
                    status_q <= 1'b0;
                end else begin
                    sync_q   <= {sync_q[SYNC_STAGES-2:0], pad[i]};
                    stable_q <= stable_d;
                    cnt_q    <= cnt_d;
                    // A new event wins over a simultaneous clear.
                    status_q <= (evt & irq_en) | (status_q & ~irq_clear[i]);
                end
            end

            assign to_core[i]    = stable_q;
            assign irq_status[i] = status_q;
        end
    endgenerate

    assign irq = |irq_status;

endmodule

// File: tb/tb_io_bank.sv
// tb/tb_io_bank.sv - self-checking bench for io_bank with a behavioural reference model

module tb_io_bank;

    localparam int N_CH = 8;
    localparam int CW   = 6;
    localparam int SS   = 2;
    localparam int FL   = 8;

    logic                  clk_in    = 1'b0;
    logic                  reset_int = 1'b1;
    logic [N_CH*CW-1:0]    io_cfg;
    logic [CW-1:0]         cfg_ch [N_CH];
    logic [N_CH-1:0]       from_core = '0;
    logic [N_CH-1:0]       irq_clear = '0;
    logic [N_CH-1:0]       tb_oe     = '0;
    logic [N_CH-1:0]       tb_val    = '0;
    logic [N_CH-1:0]       to_core;
    logic [N_CH-1:0]       irq_status;
    logic                  irq;
    wire  [N_CH-1:0]       pad;

    int tests = 0;
    int fails = 0;

    always #5 clk_in = ~clk_in;

    always_comb begin
        io_cfg = '0;
        for (int c = 0; c < N_CH; c++) io_cfg[c*CW +: CW] = cfg_ch[c];
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_drv
        assign pad[g] = tb_oe[g] ? tb_val[g] : 1'bz;
    end

    io_bank #(.N_CH(N_CH), .CONF_WIDTH(CW), .SYNC_STAGES(SS), .FILT_LEN(FL)) dut (
        .clk_in     (clk_in),
        .reset_int  (reset_int),
        .io_cfg     (io_cfg),
        .from_core  (from_core),
        .to_core    (to_core),
        .irq_clear  (irq_clear),
        .irq_status (irq_status),
        .irq        (irq),
        .pad        (pad)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: pad samples delayed by SS edges, then a run-length filter.
    bit              m_hist [N_CH][$];
    logic [N_CH-1:0] m_to = '0;
    logic [N_CH-1:0] m_st = '0;
    int              m_run [N_CH];

    function automatic bit is_rx(input int c);
        bit r;
        r = cfg_ch[c][0];
`ifdef IO_BANK_OPEN_DRAIN_EN
        r = r | cfg_ch[c][5];
`endif
        return r;
    endfunction

    always @(posedge clk_in or negedge reset_int) begin
        bit s, old_v, new_v, ev;
        if (!reset_int) begin
            for (int c = 0; c < N_CH; c++) begin
                m_hist[c].delete();
                for (int k = 0; k < SS; k++) m_hist[c].push_back(1'b0);
                m_run[c] = 0;
            end
            m_to = '0;
            m_st = '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                s = m_hist[c].pop_front();
                m_hist[c].push_back(pad[c] === 1'b1);
                old_v = m_to[c];
                new_v = old_v;
                if (!is_rx(c)) begin
                    new_v = 1'b0;
                    m_run[c] = 0;
                end else if (!cfg_ch[c][1]) begin
                    new_v = s;
                    m_run[c] = 0;
                end else if (s == old_v) begin
                    m_run[c] = 0;
                end else begin
                    m_run[c]++;
                    if (m_run[c] == FL) begin
                        new_v = s;
                        m_run[c] = 0;
                    end
                end
                ev = 1'b0;
                if (is_rx(c)) begin
                    case (cfg_ch[c][4:3])
                        2'd0: ev = !old_v && new_v;
                        2'd1: ev = old_v && !new_v;
                        2'd2: ev = old_v != new_v;
                        default: ev = old_v;
                    endcase
                end
                if (ev && cfg_ch[c][2]) m_st[c] = 1'b1;
                else if (irq_clear[c])  m_st[c] = 1'b0;
                m_to[c] = new_v;
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk_in) begin
        logic [N_CH-1:0] pmask;
        logic [N_CH-1:0] pexp;
        pmask = '0;
        pexp  = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (!cfg_ch[c][0]) begin
`ifdef IO_BANK_OPEN_DRAIN_EN
                if (cfg_ch[c][5]) begin
                    pmask[c] = !from_core[c];
                end else begin
                    pmask[c] = 1'b1;
                end
`else
                pmask[c] = 1'b1;
`endif
                pexp[c] = from_core[c];
            end
        end
        check("model_to_core", 32'(to_core), 32'(m_to));
        check("model_irq_status", 32'(irq_status), 32'(m_st));
        check("model_irq", 32'(irq), 32'(|m_st));
        check("model_pad", 32'(pad & pmask), 32'(pexp & pmask));
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    initial begin
        bit glitch_seen;
        for (int c = 0; c < N_CH; c++) cfg_ch[c] = '0;
        from_core = 8'hA5;

        // Reset with all channels driving.
        #1 reset_int = 1'b0;
        #2;
        check("reset_pad", 32'(pad), 32'h A5);
        check("reset_to_core", 32'(to_core), 32'h0);
        check("reset_irq", 32'(irq), 32'h0);
        tick(3);
        reset_int = 1'b1;
        tick(4);
        check("post_reset_to_core", 32'(to_core), 32'h0);

        // Unfiltered rise on ch0.
        cfg_ch[0] = 6'b000101;
        tb_oe[0]  = 1'b1;
        tb_val[0] = 1'b0;
        tick(5);
        tb_val[0] = 1'b1;
        tick(2);
        check("unf_t2_to_core", 32'(to_core[0]), 32'h0);
        tick(1);
        check("unf_t3_to_core", 32'(to_core[0]), 32'h1);
        check("unf_t3_status", 32'(irq_status[0]), 32'h1);
        irq_clear[0] = 1'b1;
        tick(1);
        irq_clear[0] = 1'b0;
        check("unf_cleared", 32'(irq_status[0]), 32'h0);

        // Filtered: settle low, reject a 7-cycle pulse, accept an 8+ cycle one.
        cfg_ch[0] = 6'b000111;
        tb_val[0] = 1'b0;
        tick(12);
        check("filt_settle_low", 32'(to_core[0]), 32'h0);
        glitch_seen = 1'b0;
        tb_val[0] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (k == 7) tb_val[0] = 1'b0;
            tick(1);
            if (to_core[0] || irq_status[0]) glitch_seen = 1'b1;
        end
        check("filt_glitch_rejected", 32'(glitch_seen), 32'h0);
        tb_val[0] = 1'b1;
        tick(9);
        check("filt_t9_to_core", 32'(to_core[0]), 32'h0);
        tick(1);
        check("filt_t10_to_core", 32'(to_core[0]), 32'h1);
        check("filt_t10_status", 32'(irq_status[0]), 32'h1);

        // Turn the filter off mid-count.
        tb_val[0] = 1'b0;
        tick(5);
        cfg_ch[0] = 6'b000101;
        tick(1);
        check("filt_off_immediate", 32'(to_core[0]), 32'h0);
        irq_clear[0] = 1'b1;
        tick(1);
        irq_clear[0] = 1'b0;

        // Edge modes: ch1 fall, ch2 both, ch3 level-high.
        cfg_ch[1] = 6'b001101;
        cfg_ch[2] = 6'b010101;
        cfg_ch[3] = 6'b011101;
        tb_oe[3:1]  = 3'b111;
        tb_val[3:1] = 3'b000;
        tick(5);
        irq_clear = 8'h0E;
        tick(1);
        irq_clear = '0;
        check("edge_idle", 32'(irq_status[3:1]), 32'h0);
        tb_val[3:1] = 3'b111;
        tick(3);
        check("edge_rise_t3", 32'(irq_status[3:1]), 32'b010);
        tick(1);
        check("edge_rise_t4", 32'(irq_status[3:1]), 32'b110);
        irq_clear[3:1] = 3'b111;
        tick(2);
        check("level_holds_vs_clear", 32'(irq_status[3:1]), 32'b100);
        irq_clear   = 8'h08;
        tb_val[3:1] = 3'b000;
        tick(3);
        check("edge_fall_t3", 32'(irq_status[3:1]), 32'b111);
        tick(1);
        check("level_cleared_low", 32'(irq_status[3:1]), 32'b011);
        irq_clear = 8'hFF;
        tick(2);
        irq_clear = '0;
        check("all_clear_irq", 32'(irq), 32'h0);

        // Clear on the same edge as a rise: set wins.
        tb_val[0] = 1'b1;
        tick(2);
        irq_clear[0] = 1'b1;
        tick(1);
        check("clr_prio_set_wins", 32'(irq_status[0]), 32'h1);
        tick(1);
        irq_clear[0] = 1'b0;
        check("clr_next_edge", 32'(irq_status[0]), 32'h0);
        check("clr_irq_low", 32'(irq), 32'h0);

        // irq_en = 0 blocks new sets but keeps existing status.
        tb_val[2] = 1'b1;
        tick(4);
        cfg_ch[2] = 6'b010001;
        tb_val[2] = 1'b0;
        tick(4);
        check("irq_en_off_retains", 32'(irq_status[2]), 32'h1);
        irq_clear[2] = 1'b1;
        tick(1);
        irq_clear[2] = 1'b0;
        tb_val[2] = 1'b1;
        tick(4);
        check("irq_en_off_blocks", 32'(irq_status[2]), 32'h0);

        // Direction out -> in on ch5 with a high pad gives a rise.
        cfg_ch[5] = 6'b000101;
        tb_oe[5]  = 1'b1;
        tb_val[5] = 1'b1;
        tick(4);
        check("dir_switch_rise", 32'(irq_status[5]), 32'h1);
        check("dir_switch_to_core", 32'(to_core[5]), 32'h1);

        // Asynchronous reset mid-operation; pads still driven.
        reset_int = 1'b0;
        #2;
        check("midreset_to_core", 32'(to_core), 32'h0);
        check("midreset_status", 32'(irq_status), 32'h0);
        check("midreset_pad_drive", 32'(pad[7:6]), 32'(from_core[7:6]));
        tick(2);
        reset_int = 1'b1;
        tick(4);

`ifdef IO_BANK_OPEN_DRAIN_EN
        // Open-drain ch4 with an emulated pull-up, then an external low.
        from_core[4] = 1'b1;
        tick(1);
        cfg_ch[4] = 6'b101100;
        tb_oe[4]  = 1'b1;
        tb_val[4] = 1'b1;
        tick(5);
        check("od_pad_high", 32'(pad[4]), 32'h1);
        check("od_readback_high", 32'(to_core[4]), 32'h1);
        tb_val[4] = 1'b0;
        tick(2);
        check("od_t2_to_core", 32'(to_core[4]), 32'h1);
        tick(1);
        check("od_t3_to_core", 32'(to_core[4]), 32'h0);
        check("od_fall_irq", 32'(irq_status[4]), 32'h1);
        tb_oe[4]  = 1'b0;
        cfg_ch[4] = 6'b000000;
        tick(3);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
